// File: rtl/bcd_countdown_timer.sv
// Cascaded BCD countdown timer with IDLE/RUN/ERR control FSM and one-cycle done pulse.
// Optional: define BCD_TIMER_AUTO_RELOAD_EN to reload PRESET and keep running after reaching zero.
module bcd_countdown_timer #(
    parameter int unsigned               DIGITS = 2,
    parameter logic [4*DIGITS-1:0]       PRESET = (4*DIGITS)'(8'h59)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  error,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  zero,
    output logic                  done,
    output logic                  running
);

    localparam int unsigned W = 4 * DIGITS;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    // Saturate any non-BCD digit to 9 so the counter never holds an illegal code.
    function automatic logic [W-1:0] clamp_bcd(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
        end
        return r;
    endfunction

    // Ripple-borrow BCD decrement; a digit at 0 wraps to 9 and borrows upward.
    function automatic logic [W-1:0] dec_bcd(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    localparam logic [W-1:0] PRESET_C = clamp_bcd(PRESET);

    state_t         state_q, state_d;
    logic [W-1:0]   bcd_q, bcd_d;
    logic           done_q, done_d;
    logic           running_q, running_d;
    logic [W-1:0]   bcd_dec;
    logic           bcd_is_zero;

    assign bcd_dec     = dec_bcd(bcd_q);
    assign bcd_is_zero = (bcd_q == '0);

    // Priority: error, ERR recovery, load, stop, start, decrement.
    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        done_d  = 1'b0;
        if (error) begin
            state_d = S_ERR;
            bcd_d   = '0;
        end else if (state_q == S_ERR) begin
            state_d = S_IDLE;
        end else if (load) begin
            bcd_d = clamp_bcd(load_val);
        end else if (stop) begin
            if (state_q == S_RUN) state_d = S_IDLE;
        end else if (state_q == S_IDLE) begin
            if (start) begin
                state_d = S_RUN;
                if (bcd_is_zero) bcd_d = PRESET_C;
            end
        end else if (en) begin
`ifdef BCD_TIMER_AUTO_RELOAD_EN
            if (bcd_is_zero) begin
                bcd_d = PRESET_C;
            end else begin
                bcd_d  = bcd_dec;
                done_d = (bcd_dec == '0);
            end
`else
            if (!bcd_is_zero) begin
                bcd_d = bcd_dec;
                if (bcd_dec == '0) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
`endif
        end
        running_d = (state_d == S_RUN);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            bcd_q     <= '0;
            done_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bcd_q     <= bcd_d;
            done_q    <= done_d;
            running_q <= running_d;
        end
    end

    assign bcd     = bcd_q;
    assign zero    = bcd_is_zero;
    assign done    = done_q;
    assign running = running_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench for bcd_countdown_timer (DIGITS=2, PRESET=59); follows BCD_TIMER_AUTO_RELOAD_EN if defined.
module tb_bcd_countdown_timer;

`ifdef BCD_TIMER_AUTO_RELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset_n, start, stop, en, load, error;
    logic [7:0] load_val;
    logic [7:0] bcd;
    logic       zero, done, running;

    typedef struct packed {
        logic       rst_n;
        logic       start;
        logic       stop;
        logic       en;
        logic       load;
        logic [7:0] lv;
        logic       err;
    } stim_t;

    typedef struct packed {
        logic [7:0] bcd;
        logic       done;
        logic       run;
        logic       zero;
    } obs_t;

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    bcd_countdown_timer #(.DIGITS(2), .PRESET(8'h59)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .stop     (stop),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .error    (error),
        .bcd      (bcd),
        .zero     (zero),
        .done     (done),
        .running  (running)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic stim_t s(input logic r, input logic st, input logic sp, input logic e,
                                input logic ld, input logic [7:0] lv, input logic er);
        return '{rst_n: r, start: st, stop: sp, en: e, load: ld, lv: lv, err: er};
    endfunction

    function automatic obs_t o(input logic [7:0] b, input logic d, input logic r, input logic z);
        return '{bcd: b, done: d, run: r, zero: z};
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic drive(input stim_t x);
        @(negedge clock);
        reset_n  = x.rst_n;
        start    = x.start;
        stop     = x.stop;
        en       = x.en;
        load     = x.load;
        load_val = x.lv;
        error    = x.err;
    endtask

    task automatic test_reset();
        obs_t got, want;
        for (int i = 0; i < 2; i++) begin
            drive(s(0, 1, 0, 1, 1, 8'h45, 0));
            exp_q.push_back(o(8'h00, 0, 0, 1));
            @(posedge clock); #1;
            got  = o(bcd, done, running, zero);
            want = exp_q.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL reset[%0d]: got bcd=%h done=%b run=%b zero=%b want bcd=%h done=%b run=%b zero=%b",
                         i, got.bcd, got.done, got.run, got.zero, want.bcd, want.done, want.run, want.zero);
            end
        end
    endtask

    task automatic test_countdown();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, want;
        st.push_back(s(1, 1, 0, 1, 0, 8'h00, 0)); ex.push_back(o(8'h59, 0, 1, 0));
        for (int v = 58; v >= 1; v--) begin
            st.push_back(s(1, 1, 0, 1, 0, 8'h00, 0)); ex.push_back(o(to_bcd(v), 0, 1, 0));
        end
        st.push_back(s(1, 1, 0, 1, 0, 8'h00, 0)); ex.push_back(o(8'h00, 1, AUTO, 1));
        st.push_back(s(1, 0, 0, 1, 0, 8'h00, 0));
        ex.push_back(AUTO ? o(8'h59, 0, 1, 0) : o(8'h00, 0, 0, 1));
        foreach (st[i]) begin
            drive(st[i]);
            exp_q.push_back(ex[i]);
            @(posedge clock); #1;
            got  = o(bcd, done, running, zero);
            want = exp_q.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL countdown[%0d]: got bcd=%h done=%b run=%b zero=%b want bcd=%h done=%b run=%b zero=%b",
                         i, got.bcd, got.done, got.run, got.zero, want.bcd, want.done, want.run, want.zero);
            end
        end
    endtask

    task automatic test_load_one();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, want;
        st.push_back(s(0, 0, 0, 0, 0, 8'h00, 0)); ex.push_back(o(8'h00, 0, 0, 1));
        st.push_back(s(1, 0, 0, 0, 1, 8'h01, 0)); ex.push_back(o(8'h01, 0, 0, 0));
        st.push_back(s(1, 1, 0, 0, 0, 8'h00, 0)); ex.push_back(o(8'h01, 0, 1, 0));
        st.push_back(s(1, 0, 0, 1, 0, 8'h00, 0)); ex.push_back(o(8'h00, 1, AUTO, 1));
        st.push_back(s(1, 0, 0, 1, 0, 8'h00, 0));
        ex.push_back(AUTO ? o(8'h59, 0, 1, 0) : o(8'h00, 0, 0, 1));
        st.push_back(s(1, 0, 0, 1, 0, 8'h00, 0));
        ex.push_back(AUTO ? o(8'h58, 0, 1, 0) : o(8'h00, 0, 0, 1));
        foreach (st[i]) begin
            drive(st[i]);
            exp_q.push_back(ex[i]);
            @(posedge clock); #1;
            got  = o(bcd, done, running, zero);
            want = exp_q.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL load_one[%0d]: got bcd=%h done=%b run=%b zero=%b want bcd=%h done=%b run=%b zero=%b",
                         i, got.bcd, got.done, got.run, got.zero, want.bcd, want.done, want.run, want.zero);
            end
        end
    endtask

    task automatic test_clamp_load();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, want;
        st.push_back(s(0, 0, 0, 0, 0, 8'h00, 0)); ex.push_back(o(8'h00, 0, 0, 1));
        st.push_back(s(1, 0, 0, 0, 1, 8'hAF, 0)); ex.push_back(o(8'h99, 0, 0, 0));
        st.push_back(s(1, 1, 0, 1, 0, 8'h00, 0)); ex.push_back(o(8'h99, 0, 1, 0));
        st.push_back(s(1, 0, 0, 1, 0, 8'h00, 0)); ex.push_back(o(8'h98, 0, 1, 0));
        // load beats decrement, keeps RUN, and clamps the low digit only
        st.push_back(s(1, 0, 0, 1, 1, 8'h3C, 0)); ex.push_back(o(8'h39, 0, 1, 0));
        st.push_back(s(1, 0, 0, 1, 1, 8'h00, 0)); ex.push_back(o(8'h00, 0, 1, 1));
        st.push_back(s(1, 0, 1, 1, 0, 8'h00, 0)); ex.push_back(o(8'h00, 0, 0, 1));
        foreach (st[i]) begin
            drive(st[i]);
            exp_q.push_back(ex[i]);
            @(posedge clock); #1;
            got  = o(bcd, done, running, zero);
            want = exp_q.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL clamp_load[%0d]: got bcd=%h done=%b run=%b zero=%b want bcd=%h done=%b run=%b zero=%b",
                         i, got.bcd, got.done, got.run, got.zero, want.bcd, want.done, want.run, want.zero);
            end
        end
    endtask

    task automatic test_error();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, want;
        st.push_back(s(0, 0, 0, 0, 0, 8'h00, 0)); ex.push_back(o(8'h00, 0, 0, 1));
        st.push_back(s(1, 1, 0, 0, 0, 8'h00, 0)); ex.push_back(o(8'h59, 0, 1, 0));
        st.push_back(s(1, 1, 0, 0, 1, 8'h37, 0)); ex.push_back(o(8'h37, 0, 1, 0));
        for (int k = 0; k < 3; k++) begin
            st.push_back(s(1, 1, 0, 1, 1, 8'h42, 1)); ex.push_back(o(8'h00, 0, 0, 1));
        end
        st.push_back(s(1, 1, 0, 1, 1, 8'h42, 0)); ex.push_back(o(8'h00, 0, 0, 1));
        st.push_back(s(1, 1, 0, 0, 0, 8'h00, 0)); ex.push_back(o(8'h59, 0, 1, 0));
        foreach (st[i]) begin
            drive(st[i]);
            exp_q.push_back(ex[i]);
            @(posedge clock); #1;
            got  = o(bcd, done, running, zero);
            want = exp_q.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL error[%0d]: got bcd=%h done=%b run=%b zero=%b want bcd=%h done=%b run=%b zero=%b",
                         i, got.bcd, got.done, got.run, got.zero, want.bcd, want.done, want.run, want.zero);
            end
        end
    endtask

    task automatic test_en_toggle();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, want;
        st.push_back(s(0, 0, 0, 0, 0, 8'h00, 0)); ex.push_back(o(8'h00, 0, 0, 1));
        st.push_back(s(1, 0, 0, 0, 1, 8'h20, 0)); ex.push_back(o(8'h20, 0, 0, 0));
        st.push_back(s(1, 1, 0, 0, 0, 8'h00, 0)); ex.push_back(o(8'h20, 0, 1, 0));
        st.push_back(s(1, 0, 0, 1, 0, 8'h00, 0)); ex.push_back(o(8'h19, 0, 1, 0));
        st.push_back(s(1, 0, 0, 0, 0, 8'h00, 0)); ex.push_back(o(8'h19, 0, 1, 0));
        st.push_back(s(1, 0, 0, 1, 0, 8'h00, 0)); ex.push_back(o(8'h18, 0, 1, 0));
        st.push_back(s(1, 1, 1, 1, 0, 8'h00, 0)); ex.push_back(o(8'h18, 0, 0, 0));
        st.push_back(s(1, 1, 1, 1, 0, 8'h00, 0)); ex.push_back(o(8'h18, 0, 0, 0));
        st.push_back(s(1, 0, 0, 1, 0, 8'h00, 0)); ex.push_back(o(8'h18, 0, 0, 0));
        st.push_back(s(1, 1, 0, 1, 0, 8'h00, 0)); ex.push_back(o(8'h18, 0, 1, 0));
        st.push_back(s(1, 0, 0, 1, 0, 8'h00, 0)); ex.push_back(o(8'h17, 0, 1, 0));
        foreach (st[i]) begin
            drive(st[i]);
            exp_q.push_back(ex[i]);
            @(posedge clock); #1;
            got  = o(bcd, done, running, zero);
            want = exp_q.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL en_toggle[%0d]: got bcd=%h done=%b run=%b zero=%b want bcd=%h done=%b run=%b zero=%b",
                         i, got.bcd, got.done, got.run, got.zero, want.bcd, want.done, want.run, want.zero);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, want;
        st.push_back(s(1, 0, 0, 0, 1, 8'h05, 0)); ex.push_back(o(8'h05, 0, 1, 0));
        st.push_back(s(1, 0, 0, 1, 0, 8'h00, 0)); ex.push_back(o(8'h04, 0, 1, 0));
        st.push_back(s(1, 0, 0, 1, 1, 8'h01, 0)); ex.push_back(o(8'h01, 0, 1, 0));
        st.push_back(s(0, 1, 0, 1, 0, 8'h00, 0)); ex.push_back(o(8'h00, 0, 0, 1));
        st.push_back(s(1, 0, 0, 1, 0, 8'h00, 0)); ex.push_back(o(8'h00, 0, 0, 1));
        st.push_back(s(1, 0, 0, 1, 0, 8'h00, 0)); ex.push_back(o(8'h00, 0, 0, 1));
        foreach (st[i]) begin
            drive(st[i]);
            exp_q.push_back(ex[i]);
            @(posedge clock); #1;
            got  = o(bcd, done, running, zero);
            want = exp_q.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL reset_mid_run[%0d]: got bcd=%h done=%b run=%b zero=%b want bcd=%h done=%b run=%b zero=%b",
                         i, got.bcd, got.done, got.run, got.zero, want.bcd, want.done, want.run, want.zero);
            end
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        en       = 1'b0;
        load     = 1'b0;
        load_val = 8'h00;
        error    = 1'b0;
        test_reset();
        test_countdown();
        test_load_one();
        test_clamp_load();
        test_error();
        test_en_toggle();
        test_reset_mid_run();
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d leftover entries want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_countdown_timer.md
BCD_COUNTDOWN_TIMER -- requirements
Module: bcd_countdown_timer

Interface
REQ-001 The module SHALL have parameter DIGITS, default 2, meaning the number of cascaded BCD digits (range 1..8).
REQ-002 The module SHALL have parameter PRESET, default 8'h59, a 4*DIGITS-bit BCD reload value; digit 0 is bits [3:0].
REQ-003 The module SHALL have port clock, input, 1 bit, the single rising-edge clock.
REQ-004 The module SHALL have port reset_n, input, 1 bit, the reset, which is synchronous and active-low.
REQ-005 The module SHALL have port start, input, 1 bit, a level request to enter or remain in RUN.
REQ-006 The module SHALL have port stop, input, 1 bit, a level request to pause into IDLE.
REQ-007 The module SHALL have port en, input, 1 bit, the count enable; one decrement is made per enabled RUN cycle.
REQ-008 The module SHALL have port load, input, 1 bit, a synchronous parallel load strobe.
REQ-009 The module SHALL have port load_val, input, 4*DIGITS bits, the BCD value captured when load=1.
REQ-010 The module SHALL have port error, input, 1 bit, a fault input that forces the ERR state.
REQ-011 The module SHALL have port bcd, output, 4*DIGITS bits, the registered count.
REQ-012 The module SHALL have port zero, output, 1 bit, combinational and equal to 1 iff bcd==0.
REQ-013 The module SHALL have port done, output, 1 bit, a registered one-cycle terminal pulse.
REQ-014 The module SHALL have port running, output, 1 bit, equal to 1 iff the state is RUN.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, RUN and ERR, and all state and bcd updates SHALL occur on the rising edge of clock.
REQ-016 Per-edge priority SHALL be: reset_n=0, then error, then load, then stop, then start, then decrement.
REQ-017 With error=1 in any state: next state ERR, bcd<=0, done<=0.
REQ-018 In ERR: load, start and en are ignored, and the FSM returns to IDLE on the first edge with error=0.
REQ-019 Load: bcd<=load_val with each digit >9 clamped to 9, and the state is unchanged.
REQ-020 Stop in RUN SHALL transition to IDLE and hold bcd.
REQ-021 Start in IDLE SHALL transition to RUN; if bcd==0 at that edge, bcd<=PRESET (clamped per digit), otherwise bcd is held.
REQ-022 In RUN with en=1 and bcd!=0: bcd decrements by 1 in BCD.
REQ-023 BCD decrement rule: a digit at 0 becomes 9 and borrows from the next digit; bcd never holds a non-BCD digit.
REQ-024 In RUN with en=0: bcd is held and no pulse is generated.
REQ-025 When a decrement yields bcd==0: done=1 for exactly that following cycle; done is 0 in all other cycles.
REQ-026 Latency: the start edge is cycle 0, the first decrement occurs on the next enabled edge, and the count is visible on bcd one cycle after its edge.
REQ-027 Load and decrement in the same edge: load wins and no done is generated.
REQ-028 Start and stop asserted together: stop wins.

Reset
REQ-029 On a clock edge with reset_n=0: state<=IDLE, bcd<=0, done<=0; therefore zero=1 and running=0.
REQ-030 Reset mid-RUN SHALL abandon the count with no done pulse; reset SHALL have no asynchronous effect.

Configuration
REQ-031 Macro BCD_TIMER_AUTO_RELOAD_EN: when defined, a decrement that yields 0 pulses done, the FSM stays in RUN, and the next enabled edge loads PRESET, giving a period of PRESET+1 enabled cycles.
REQ-032 When BCD_TIMER_AUTO_RELOAD_EN is not defined, a decrement that yields 0 pulses done and the FSM transitions RUN->IDLE on the same edge.

Verification
REQ-033 reset_n=0 for 2 edges, then start=1 with en=1 -> bcd=59 one cycle later, then 58, 57, ..., with the 50->49 and 10->09 borrows correct.
REQ-034 load=1, load_val=8'h01, start, en=1 -> bcd=00, done=1 for one cycle; then (no macro) running=0 and bcd stays 00, or (macro) bcd=59 on the next enabled edge.
REQ-035 load_val=8'hAF with load=1 -> bcd=99 (each digit clamped).
REQ-036 In RUN at bcd=37, error=1 for 3 cycles -> bcd=00, running=0, done=0; error=0 -> IDLE; start -> bcd=59.
REQ-037 In RUN at bcd=20, en toggled 1,0,1 and then stop=start=1 -> 19, 19, 18, then IDLE with 18 held.
REQ-038 In RUN at bcd=05, reset_n=0 on one edge -> bcd=00, done never asserted, state IDLE.
